// File: rtl/bp_update_queue.sv
// In-order queue from branch resolution to the gshare predictor's single update port.
// Optional same-cycle bypass on an empty queue is enabled by defining BP_UPDQ_BYPASS_EN.
module bp_update_queue #(
  parameter int PC_BITS = 32,
  parameter int DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid_0,
  input  logic [PC_BITS-1:0]       in_pc_0,
  input  logic                     in_taken_0,
  input  logic                     in_valid_1,
  input  logic [PC_BITS-1:0]       in_pc_1,
  input  logic                     in_taken_1,
  output logic                     in_ready,
  input  logic                     upd_stall,
  output logic                     upd_wr_en,
  output logic [PC_BITS-1:0]       upd_pc,
  output logic                     upd_taken,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_BITS-1:0] pc_mem [DEPTH];
  logic [DEPTH-1:0]   taken_mem;
  logic [AW-1:0]      head, tail;
  logic [CW-1:0]      cnt;

  logic acc_0, acc_1, pop, bypass, wr_0, wr_1;
  logic [AW-1:0] idx_1;

  assign count = cnt;

  always_comb begin
    in_ready = (cnt <= CW'(DEPTH - 2));
    acc_0    = in_valid_0 && in_ready;
    acc_1    = in_valid_1 && in_ready;
    pop      = (cnt != '0) && !upd_stall;
`ifdef BP_UPDQ_BYPASS_EN
    bypass   = (cnt == '0) && !upd_stall && (acc_0 || acc_1);
`else
    bypass   = 1'b0;
`endif
    // Bypass consumes the oldest accepted lane; only a younger lane 1 goes to storage.
    wr_0     = acc_0 && !bypass;
    wr_1     = acc_1 && !(bypass && !acc_0);
    idx_1    = tail + AW'(wr_0);
  end

  always_comb begin
    upd_wr_en = pop || bypass;
    upd_pc    = pc_mem[head];
    upd_taken = taken_mem[head];
    if (bypass) begin
      upd_pc    = acc_0 ? in_pc_0 : in_pc_1;
      upd_taken = acc_0 ? in_taken_0 : in_taken_1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      taken_mem <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) pc_mem[i] <= '0;
    end else begin
      if (wr_0) begin
        pc_mem[tail]    <= in_pc_0;
        taken_mem[tail] <= in_taken_0;
      end
      if (wr_1) begin
        pc_mem[idx_1]    <= in_pc_1;
        taken_mem[idx_1] <= in_taken_1;
      end
      tail <= tail + AW'(wr_0) + AW'(wr_1);
      head <= head + AW'(pop);
      cnt  <= cnt + CW'(wr_0) + CW'(wr_1) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_bp_update_queue.sv
// Directed plus randomized bench for bp_update_queue against a queue-based reference model.
module tb_bp_update_queue;

  localparam int PC_BITS = 32;
  localparam int DEPTH   = 8;

  logic clk, rst_n;
  logic in_valid_0, in_taken_0, in_valid_1, in_taken_1, upd_stall;
  logic [PC_BITS-1:0] in_pc_0, in_pc_1;
  logic in_ready, upd_wr_en, upd_taken;
  logic [PC_BITS-1:0] upd_pc;
  logic [$clog2(DEPTH):0] count;

  bp_update_queue #(.PC_BITS(PC_BITS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_0(in_valid_0), .in_pc_0(in_pc_0), .in_taken_0(in_taken_0),
    .in_valid_1(in_valid_1), .in_pc_1(in_pc_1), .in_taken_1(in_taken_1),
    .in_ready(in_ready), .upd_stall(upd_stall), .upd_wr_en(upd_wr_en),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PC_BITS-1:0] pc;
    logic               taken;
  } ent_t;

  ent_t q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs against the model, advance model.
  task automatic step(input logic v0, input logic [PC_BITS-1:0] p0, input logic t0,
                      input logic v1, input logic [PC_BITS-1:0] p1, input logic t1,
                      input logic st);
    logic rdy, a0, a1, exp_wr, exp_t;
    logic [PC_BITS-1:0] exp_pc;
    ent_t e;
    @(negedge clk);
    in_valid_0 = v0; in_pc_0 = p0; in_taken_0 = t0;
    in_valid_1 = v1; in_pc_1 = p1; in_taken_1 = t1;
    upd_stall  = st;
    #1;
    rdy    = (DEPTH - q.size()) >= 2;
    a0     = v0 && rdy;
    a1     = v1 && rdy;
    exp_wr = (q.size() != 0) && !st;
    exp_pc = '0;
    exp_t  = 1'b0;
    if (q.size() != 0) begin
      exp_pc = q[0].pc;
      exp_t  = q[0].taken;
    end
`ifdef BP_UPDQ_BYPASS_EN
    if (q.size() == 0 && !st && (a0 || a1)) begin
      exp_wr = 1'b1;
      exp_pc = a0 ? p0 : p1;
      exp_t  = a0 ? t0 : t1;
    end
`endif
    chk("in_ready", 64'(in_ready), 64'(rdy));
    chk("upd_wr_en", 64'(upd_wr_en), 64'(exp_wr));
    chk("count", 64'(count), 64'(q.size()));
    if (exp_wr || q.size() != 0) begin
      chk("upd_pc", 64'(upd_pc), 64'(exp_pc));
      chk("upd_taken", 64'(upd_taken), 64'(exp_t));
    end
    @(posedge clk);
    if (a0) begin e.pc = p0; e.taken = t0; q.push_back(e); end
    if (a1) begin e.pc = p1; e.taken = t1; q.push_back(e); end
    if (exp_wr) void'(q.pop_front());
  endtask

  task automatic idle(input logic st);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, st);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid_0 = 1'b0; in_pc_0 = '0; in_taken_0 = 1'b0;
    in_valid_1 = 1'b0; in_pc_1 = '0; in_taken_1 = 1'b0;
    upd_stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_wr_en", 64'(upd_wr_en), 64'd0);
    chk("rst_pc", 64'(upd_pc), 64'd0);
    chk("rst_taken", 64'(upd_taken), 64'd0);
    repeat (3) idle(1'b0);

    // Single lane-0 push, then drain.
    step(1'b1, 32'h100, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    repeat (2) idle(1'b0);

    // Sustained dual pushes overrun the single-drain rate.
    repeat (14) step(1'b1, 32'h200, 1'b1, 1'b1, 32'h204, 1'b0, 1'b0);
    repeat (DEPTH + 2) idle(1'b0);

    // Fill completely under stall, then release.
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h400 + 32'(8 * i), 1'b1, 1'b1, 32'h404 + 32'(8 * i), 1'b0, 1'b1);
    #1;
    chk("full_count", 64'(count), 64'd8);
    chk("full_ready", 64'(in_ready), 64'd0);
    repeat (DEPTH + 2) idle(1'b0);

    // Lane-1-only interleaved with lane-0-only across several pointer wraps.
    for (int i = 0; i < 3 * DEPTH + 4; i++) begin
      if (i % 2 == 0) step(1'b0, 32'hdead, 1'b1, 1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'($urandom_range(0, 3) == 0));
      else            step(1'b1, 32'h500 + 32'(4 * i), 1'b1, 1'b0, 32'hbeef, 1'b1, 1'($urandom_range(0, 3) == 0));
    end
    repeat (DEPTH + 4) idle(1'b0);

    // count=6, dual push with pop in the same cycle.
    repeat (3) step(1'b1, 32'h600, 1'b0, 1'b1, 32'h604, 1'b1, 1'b1);
    #1;
    chk("pre_count6", 64'(count), 64'd6);
    step(1'b1, 32'h608, 1'b1, 1'b1, 32'h60c, 1'b0, 1'b0);
    #1;
    chk("after_count7", 64'(count), 64'd7);
    chk("after_ready0", 64'(in_ready), 64'd0);
    repeat (DEPTH + 2) idle(1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0));

    // Asynchronous reset mid-drain at count=5.
    repeat (DEPTH + 2) idle(1'b0);
    step(1'b1, 32'h700, 1'b1, 1'b1, 32'h704, 1'b1, 1'b1);
    step(1'b1, 32'h708, 1'b0, 1'b1, 32'h70c, 1'b1, 1'b1);
    step(1'b1, 32'h710, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    in_valid_0 = 1'b0; in_valid_1 = 1'b0; upd_stall = 1'b0;
    #1;
    chk("pre_rst_count5", 64'(count), 64'd5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_wr_en", 64'(upd_wr_en), 64'd0);
    chk("async_rst_ready", 64'(in_ready), 64'd1);
    chk("async_rst_pc", 64'(upd_pc), 64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) idle(1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 32'h800, 1'b1, 1'b0);
    repeat (2) idle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
